// File: rtl/dump_pkg.sv
// Shared types for the result dump streamer: FSM states, beat tags, read sources.
package dump_pkg;

    // Dump sequencer states; CSUM is only entered when the checksum beat is built in.
    typedef enum logic [2:0] {
        IDLE,
        IMG,
        HIST,
        CSUM,
        DRAIN
    } dump_state_e;

    // Where the captured read data comes from.
    typedef enum logic [1:0] {
        SRC_IMG,
        SRC_HIST,
        SRC_CSUM
    } rd_src_e;

    // Section field is sized for up to 14 histogram channels; the top trims it to its port width.
    localparam int TAG_SEC_W = 4;

    typedef struct packed {
        logic [TAG_SEC_W-1:0] sec;
        logic                 eos;
        logic                 last;
    } beat_tag_t;

    localparam logic [TAG_SEC_W-1:0] SEC_IMG = '0;

    // Section number of histogram channel ch (image is section 0).
    function automatic logic [TAG_SEC_W-1:0] hist_sec(input int unsigned ch);
        return TAG_SEC_W'(ch + 1);
    endfunction

endpackage

// File: rtl/dump_skid_buffer.sv
// Two-entry FIFO holding payload+tag for the output stream; the sole storage behind out_*.
module dump_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_srst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign w_push_ok = i_push && (r_count != 2'd2);
    assign w_pop_ok  = i_pop && (r_count != 2'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic [W-1:0] r_slot;
            // Each slot captures pushed data when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (i_srst) begin
                    r_slot <= '0;
                end else if (w_push_ok && (r_wr_ptr == 1'(gi))) begin
                    r_slot <= i_data;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign o_data  = r_rd_ptr ? g_slot[1].r_slot : g_slot[0].r_slot;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/result_dump_streamer.sv
// Streams the image memory, then every histogram channel, as one valid/ready beat stream
// once per rising edge of finish. Define DUMP_CHECKSUM_EN to append an XOR checksum beat.
module result_dump_streamer
    import dump_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int IMG_DEPTH = 8192,
    parameter int HIST_CH   = 2,
    parameter int HIST_BINS = 256,
    parameter int HIST_W    = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      finish,
    output logic [$clog2(IMG_DEPTH)-1:0]              img_addr,
    input  logic [DATA_W-1:0]                         img_rdata,
    output logic [((HIST_CH > 1) ? $clog2(HIST_CH) : 1)-1:0] hist_sel,
    output logic [$clog2(HIST_BINS)-1:0]              hist_addr,
    input  logic [HIST_W-1:0]                         hist_rdata,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_W-1:0]                         out_data,
    output logic [$clog2(HIST_CH+2)-1:0]              out_sec,
    output logic                                      out_eos,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int IMG_AW = $clog2(IMG_DEPTH);
    localparam int CH_W   = (HIST_CH > 1) ? $clog2(HIST_CH) : 1;
    localparam int BIN_W  = $clog2(HIST_BINS);
    localparam int SEC_W  = $clog2(HIST_CH + 2);
    localparam int PAY_W  = DATA_W + $bits(beat_tag_t);

    dump_state_e         r_state;
    dump_state_e         w_state_next;
    logic                r_finish_q;
    logic [IMG_AW-1:0]   r_img_addr;
    logic [CH_W-1:0]     r_ch;
    logic [BIN_W-1:0]    r_bin;
    logic                r_rd_vld;
    beat_tag_t           r_rd_tag;
    rd_src_e             r_rd_src;

    logic                w_issue;
    beat_tag_t           w_issue_tag;
    rd_src_e             w_issue_src;
    logic                w_done;
    logic                w_img_last;
    logic                w_bin_last;
    logic                w_ch_last;
    logic                w_pop;
    logic [1:0]          w_count;
    logic [2:0]          w_occ;
    logic                w_room;
    logic [DATA_W-1:0]   w_push_data;
    logic [PAY_W-1:0]    w_fifo_out;
    logic [DATA_W-1:0]   w_out_data;
    beat_tag_t           w_out_tag;
    logic                w_unused_sec;

    assign w_img_last = (r_img_addr == IMG_AW'(IMG_DEPTH - 1));
    assign w_bin_last = (r_bin == BIN_W'(HIST_BINS - 1));
    assign w_ch_last  = (r_ch == CH_W'(HIST_CH - 1));

    // A beat leaving this cycle frees a slot, so counting it keeps one beat per cycle flowing.
    assign w_pop  = out_valid && out_ready;
    assign w_occ  = {1'b0, w_count} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_room = (w_occ < 3'd2);

    // State register plus finish edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_finish_q <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_finish_q <= finish;
        end
    end

    // Next-state logic and read issue with the tags that travel with each read.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_tag  = '0;
        w_issue_src  = SRC_IMG;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (finish && !r_finish_q) begin
                    w_state_next = IMG;
                end
            end
            IMG: begin
                if (w_room) begin
                    w_issue         = 1'b1;
                    w_issue_tag.sec = SEC_IMG;
                    w_issue_tag.eos = w_img_last;
                    if (w_img_last) begin
                        w_state_next = HIST;
                    end
                end
            end
            HIST: begin
                if (w_room) begin
                    w_issue         = 1'b1;
                    w_issue_src     = SRC_HIST;
                    w_issue_tag.sec = hist_sec(32'(r_ch));
                    w_issue_tag.eos = w_bin_last;
`ifdef DUMP_CHECKSUM_EN
                    w_issue_tag.last = 1'b0;
                    if (w_bin_last && w_ch_last) begin
                        w_state_next = CSUM;
                    end
`else
                    w_issue_tag.last = w_bin_last && w_ch_last;
                    if (w_bin_last && w_ch_last) begin
                        w_state_next = DRAIN;
                    end
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (w_room) begin
                    w_issue          = 1'b1;
                    w_issue_src      = SRC_CSUM;
                    w_issue_tag.sec  = TAG_SEC_W'(HIST_CH + 1);
                    w_issue_tag.eos  = 1'b1;
                    w_issue_tag.last = 1'b1;
                    w_state_next     = DRAIN;
                end
            end
`endif
            DRAIN: begin
                if ((w_count == 2'd0) && !r_rd_vld) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read address counters; each wraps to 0 after its final read so the next dump starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_img_addr <= '0;
            r_ch       <= '0;
            r_bin      <= '0;
        end else if (w_issue) begin
            if (r_state == IMG) begin
                r_img_addr <= w_img_last ? '0 : r_img_addr + 1'b1;
            end else if (r_state == HIST) begin
                r_bin <= w_bin_last ? '0 : r_bin + 1'b1;
                if (w_bin_last) begin
                    r_ch <= w_ch_last ? '0 : r_ch + 1'b1;
                end
            end
        end
    end

    // In-flight read tracking: the memories answer one cycle after the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld <= 1'b0;
            r_rd_tag <= '0;
            r_rd_src <= SRC_IMG;
        end else begin
            r_rd_vld <= w_issue;
            r_rd_tag <= w_issue_tag;
            r_rd_src <= w_issue_src;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    // XOR of every data beat pushed since the start edge.
    always_ff @(posedge clk) begin
        if (reset || ((r_state == IDLE) && finish && !r_finish_q)) begin
            r_csum <= '0;
        end else if (r_rd_vld && (r_rd_src != SRC_CSUM)) begin
            r_csum <= r_csum ^ w_push_data;
        end
    end
`endif

    // Select the payload for the captured read; histogram bins are zero-extended.
    always_comb begin
        w_push_data = img_rdata;
        case (r_rd_src)
            SRC_HIST: w_push_data = DATA_W'(hist_rdata);
`ifdef DUMP_CHECKSUM_EN
            SRC_CSUM: w_push_data = r_csum;
`else
            SRC_CSUM: w_push_data = '0;
`endif
            default:  w_push_data = img_rdata;
        endcase
    end

    dump_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk     (clk),
        .i_srst  (reset),
        .i_push  (r_rd_vld),
        .i_data  ({w_push_data, r_rd_tag}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    assign {w_out_data, w_out_tag} = w_fifo_out;
    assign w_unused_sec = ^w_out_tag.sec;

    assign out_data  = w_out_data;
    assign out_sec   = w_out_tag.sec[SEC_W-1:0];
    assign out_eos   = w_out_tag.eos;
    assign out_last  = w_out_tag.last;
    assign img_addr  = r_img_addr;
    assign hist_sel  = r_ch;
    assign hist_addr = r_bin;
    assign busy      = (r_state != IDLE);
    assign done      = w_done;

endmodule

// File: tb/tb_result_dump_streamer.sv
// Directed bench for result_dump_streamer in its small configuration.
module tb_result_dump_streamer;

    localparam int DATA_W    = 32;
    localparam int IMG_DEPTH = 4;
    localparam int HIST_CH   = 2;
    localparam int HIST_BINS = 4;
    localparam int HIST_W    = 16;
`ifdef DUMP_CHECKSUM_EN
    localparam int N_BEATS = 13;
`else
    localparam int N_BEATS = 12;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        finish;
    logic [1:0]  img_addr;
    logic [31:0] img_rdata;
    logic [0:0]  hist_sel;
    logic [1:0]  hist_addr;
    logic [15:0] hist_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sec;
    logic        out_eos;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] img_mem [IMG_DEPTH];
    logic [15:0] hist_mem [HIST_CH][HIST_BINS];

    logic [31:0] exp_data [N_BEATS];
    logic [1:0]  exp_sec  [N_BEATS];
    logic        exp_eos  [N_BEATS];
    logic        exp_last [N_BEATS];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_data;
    logic [1:0]  last_sec;
    logic        last_last;
    logic        prev_last;

    result_dump_streamer #(
        .DATA_W    (DATA_W),
        .IMG_DEPTH (IMG_DEPTH),
        .HIST_CH   (HIST_CH),
        .HIST_BINS (HIST_BINS),
        .HIST_W    (HIST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .finish     (finish),
        .img_addr   (img_addr),
        .img_rdata  (img_rdata),
        .hist_sel   (hist_sel),
        .hist_addr  (hist_addr),
        .hist_rdata (hist_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sec    (out_sec),
        .out_eos    (out_eos),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory models with one-cycle read latency.
    always @(posedge clk) begin
        img_rdata  <= img_mem[img_addr];
        hist_rdata <= hist_mem[hist_sel][hist_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected beat list: image words, then each channel's bins, then the optional checksum.
    task automatic build_exp();
        int          k;
        logic [31:0] x;
        k = 0;
        x = '0;
        for (int i = 0; i < IMG_DEPTH; i++) begin
            exp_data[k] = img_mem[i];
            exp_sec[k]  = 2'd0;
            exp_eos[k]  = (i == IMG_DEPTH - 1);
            exp_last[k] = 1'b0;
            x = x ^ img_mem[i];
            k++;
        end
        for (int c = 0; c < HIST_CH; c++) begin
            for (int b = 0; b < HIST_BINS; b++) begin
                exp_data[k] = {16'h0000, hist_mem[c][b]};
                exp_sec[k]  = 2'(c + 1);
                exp_eos[k]  = (b == HIST_BINS - 1);
                exp_last[k] = (c == HIST_CH - 1) && (b == HIST_BINS - 1) && (N_BEATS == 12);
                x = x ^ {16'h0000, hist_mem[c][b]};
                k++;
            end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_data[k] = x;
        exp_sec[k]  = 2'(HIST_CH + 1);
        exp_eos[k]  = 1'b1;
        exp_last[k] = 1'b1;
`endif
    endtask

    // Called at a negedge: raises finish and checks the two-cycle first-beat latency.
    task automatic start_dump(input string tag, input bit hold);
        finish = 1'b1;
        @(negedge clk);
        if (!hold) finish = 1'b0;
        check({tag, "_busy_after_edge"}, 64'(busy), 64'd1);
        check({tag, "_valid_c1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid_c2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_first_valid"}, 64'(out_valid), 64'd1);
    endtask

    // Consumes beats against the expected list; optionally stops after abort_at beats
    // or re-pulses finish at cycle repulse_at.
    task automatic collect(input string tag, input bit rand_ready, input int abort_at,
                           input int repulse_at, output int nbeats, output int done_cyc);
        logic        stalled;
        logic [31:0] h_data;
        logic [1:0]  h_sec;
        logic        h_eos;
        logic        h_last;
        int          ndone;
        nbeats   = 0;
        done_cyc = -1;
        stalled  = 1'b0;
        ndone    = 0;
        h_data   = '0;
        h_sec    = '0;
        h_eos    = 1'b0;
        h_last   = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (repulse_at >= 0) begin
                if (cyc == repulse_at) finish = 1'b1;
                else if (cyc == repulse_at + 1) finish = 1'b0;
            end
            if (stalled) begin
                check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_stall_data"}, 64'(out_data), 64'(h_data));
                check({tag, "_stall_tag"}, 64'({out_sec, out_eos, out_last}),
                      64'({h_sec, h_eos, h_last}));
            end
            if (done) begin
                check({tag, "_beats_at_done"}, 64'(nbeats), 64'(N_BEATS));
                check({tag, "_valid_at_done"}, 64'(out_valid), 64'd0);
                done_cyc = cyc;
                ndone++;
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (nbeats < N_BEATS) begin
                    check($sformatf("%s_data_%0d", tag, nbeats), 64'(out_data), 64'(exp_data[nbeats]));
                    check($sformatf("%s_sec_%0d", tag, nbeats), 64'(out_sec), 64'(exp_sec[nbeats]));
                    check($sformatf("%s_eos_%0d", tag, nbeats), 64'(out_eos), 64'(exp_eos[nbeats]));
                    check($sformatf("%s_last_%0d", tag, nbeats), 64'(out_last), 64'(exp_last[nbeats]));
                end else begin
                    check({tag, "_extra_beat"}, 64'(nbeats), 64'(N_BEATS - 1));
                end
                prev_last = last_last;
                last_data = out_data;
                last_sec  = out_sec;
                last_last = out_last;
                nbeats++;
                stalled = 1'b0;
                if ((abort_at > 0) && (nbeats == abort_at)) begin
                    @(negedge clk);
                    return;
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                h_data  = out_data;
                h_sec   = out_sec;
                h_eos   = out_eos;
                h_last  = out_last;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(ndone), 64'd1);
        if (ndone != 0) begin
            @(negedge clk);
            check({tag, "_done_pulse_width"}, 64'(done), 64'd0);
            check({tag, "_idle_after_done"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int nb;
        int dc;
        int cnt;

        reset     = 1'b1;
        finish    = 1'b0;
        out_ready = 1'b0;
        last_data = '0;
        last_sec  = '0;
        last_last = 1'b0;
        prev_last = 1'b0;
        for (int i = 0; i < IMG_DEPTH; i++) img_mem[i] = 32'h0000_00A0 + 32'(i);
        for (int b = 0; b < HIST_BINS; b++) begin
            hist_mem[0][b] = 16'(b + 1);
            hist_mem[1][b] = 16'(b + 5);
        end
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_tags", 64'({out_sec, out_eos, out_last}), 64'd0);
        check("rst_addrs", 64'({img_addr, hist_sel, hist_addr}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state checked");

        // Basic stream, consumer always ready.
        build_exp();
        out_ready = 1'b1;
        start_dump("basic", 1'b0);
        collect("basic", 1'b0, -1, -1, nb, dc);
        check("basic_beats", 64'(nb), 64'(N_BEATS));
        check("basic_done_cycle", 64'(dc), 64'(N_BEATS));
`ifndef DUMP_CHECKSUM_EN
        check("basic_final_data", 64'(last_data), 64'h8);
        check("basic_final_last", 64'(last_last), 64'd1);
        check("basic_final_sec", 64'(last_sec), 64'd2);
`endif
        $display("[TB] basic dump: %0d beats, done at cycle %0d", nb, dc);

        // Random backpressure.
        start_dump("bp", 1'b0);
        collect("bp", 1'b1, -1, -1, nb, dc);
        check("bp_beats", 64'(nb), 64'(N_BEATS));
        $display("[TB] backpressure dump: %0d beats", nb);

        // Level finish: held high must not re-trigger.
        out_ready = 1'b1;
        start_dump("lvl", 1'b1);
        collect("lvl", 1'b0, -1, -1, nb, dc);
        check("lvl_beats", 64'(nb), 64'(N_BEATS));
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid || busy || done) cnt++;
            @(negedge clk);
        end
        check("lvl_no_retrigger", 64'(cnt), 64'd0);
        finish = 1'b0;
        @(negedge clk);
        start_dump("lvl2", 1'b0);
        collect("lvl2", 1'b0, -1, -1, nb, dc);
        check("lvl2_beats", 64'(nb), 64'(N_BEATS));
        $display("[TB] level finish: second dump %0d beats", nb);

        // Start edge while busy is ignored.
        start_dump("sbusy", 1'b0);
        collect("sbusy", 1'b0, -1, 3, nb, dc);
        check("sbusy_beats", 64'(nb), 64'(N_BEATS));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) cnt++;
            @(negedge clk);
        end
        check("sbusy_no_second_dump", 64'(cnt), 64'd0);
        $display("[TB] start while busy: %0d beats", nb);

        // Reset after five accepted beats.
        start_dump("rmid", 1'b0);
        collect("rmid", 1'b0, 5, -1, nb, dc);
        check("rmid_beats_before_reset", 64'(nb), 64'd5);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_valid", 64'(out_valid), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_done", 64'(done), 64'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || done || busy) cnt++;
            @(negedge clk);
        end
        check("rmid_quiet", 64'(cnt), 64'd0);
        start_dump("rrestart", 1'b0);
        collect("rrestart", 1'b0, -1, -1, nb, dc);
        check("rrestart_beats", 64'(nb), 64'(N_BEATS));
        $display("[TB] reset mid-dump: restart produced %0d beats", nb);

`ifdef DUMP_CHECKSUM_EN
        // Checksum beat over img={1,2,4,8}, histograms zero.
        img_mem[0] = 32'h1;
        img_mem[1] = 32'h2;
        img_mem[2] = 32'h4;
        img_mem[3] = 32'h8;
        for (int c = 0; c < HIST_CH; c++)
            for (int b = 0; b < HIST_BINS; b++) hist_mem[c][b] = 16'h0;
        build_exp();
        start_dump("csum", 1'b0);
        collect("csum", 1'b0, -1, -1, nb, dc);
        check("csum_beats", 64'(nb), 64'd13);
        check("csum_value", 64'(last_data), 64'h0000_000F);
        check("csum_sec", 64'(last_sec), 64'd3);
        check("csum_last", 64'(last_last), 64'd1);
        check("csum_beat12_last", 64'(prev_last), 64'd0);
        $display("[TB] checksum dump: %0d beats, checksum 0x%08h", nb, last_data);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
